// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle 8-bit-instruction CPU core with four general registers,
// a parametrised datapath and req/ready handshakes to external instruction and
// data memories. Each instruction passes through FETCH and EXEC; loads and stores
// add a MEM phase. Opcode 111 with a zero immediate stops the core until reset.
module mc_cpu_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int PC_WIDTH    = 8,
    parameter int DADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   i_req,
    output logic [PC_WIDTH-1:0]    i_addr,
    input  logic                   i_ready,
    input  logic [7:0]             i_data,
    output logic                   d_req,
    output logic                   d_we,
    output logic [DADDR_WIDTH-1:0] d_addr,
    output logic [DATA_WIDTH-1:0]  d_wdata,
    input  logic                   d_ready,
    input  logic [DATA_WIDTH-1:0]  d_rdata,
    output logic                   halted
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_LDH = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_LDL = 3'b110;
    localparam logic [2:0] OP_BGT = 3'b111;

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [DATA_WIDTH-1:0]    regs_q [4];
    logic [DATA_WIDTH-1:0]    regs_d [4];
    logic                     gt_q, gt_d;
    logic [7:0]               ir_q, ir_d;
    logic                     i_req_q, i_req_d;
    logic                     d_req_q, d_req_d;
    logic                     d_we_q, d_we_d;
    logic [DADDR_WIDTH-1:0]   d_addr_q, d_addr_d;
    logic [DATA_WIDTH-1:0]    d_wdata_q, d_wdata_d;
    logic                     halted_q, halted_d;

    logic [2:0]               op;
    logic [1:0]               rd_idx;
    logic [1:0]               rs_idx;
    logic [1:0]               dir_idx;
    logic [3:0]               imm;
    logic [DATA_WIDTH-1:0]    rd_val;
    logic [DATA_WIDTH-1:0]    rs_val;
    logic [DATA_WIDTH-1:0]    alu_res;
    logic [PC_WIDTH-1:0]      pc_inc;
    logic [PC_WIDTH-1:0]      imm_pc;
    logic                     fetch_done;
    logic                     mem_done;
    logic                     is_halt;
    logic                     is_mem;

    // Instruction field decode from the latched instruction register.
    assign op         = ir_q[7:5];
    assign rd_idx     = ir_q[4:3];
    assign rs_idx     = ir_q[2:1];
    assign dir_idx    = {1'b0, ir_q[4]};
    assign imm        = ir_q[3:0];
    assign rd_val     = regs_q[rd_idx];
    assign rs_val     = regs_q[rs_idx];
    assign pc_inc     = pc_q + PC_WIDTH'(1);
    assign imm_pc     = PC_WIDTH'(imm);
    assign fetch_done = i_req_q && i_ready;
    assign mem_done   = d_req_q && d_ready;
    assign is_halt    = (op == OP_BGT) && (imm == 4'd0);
    assign is_mem     = (op == OP_LD) || (op == OP_ST);

    // Ports are driven straight from flops; the fetch address is the PC itself.
    assign i_req   = i_req_q;
    assign i_addr  = pc_q;
    assign d_req   = d_req_q;
    assign d_we    = d_we_q;
    assign d_addr  = d_addr_q;
    assign d_wdata = d_wdata_q;
    assign halted  = halted_q;

    // ALU result for the three register-register operations.
    always_comb begin
        alu_res = rd_val + rs_val;
        case (op)
            OP_SUB:  alu_res = rd_val - rs_val;
            OP_AND:  alu_res = rd_val & rs_val;
            default: alu_res = rd_val + rs_val;
        endcase
    end

    // State register; reset returns the sequencer to START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stalls in FETCH/MEM until the matching ready arrives.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (fetch_done) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    // Datapath and registered-output updates for each state; everything holds by default.
    always_comb begin
        pc_d      = pc_q;
        regs_d    = regs_q;
        gt_d      = gt_q;
        ir_d      = ir_q;
        i_req_d   = i_req_q;
        d_req_d   = d_req_q;
        d_we_d    = d_we_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        halted_d  = halted_q;
        unique case (state_q)
            S_START: begin
                i_req_d = 1'b1;
            end
            S_FETCH: begin
                if (fetch_done) begin
                    ir_d    = i_data;
                    i_req_d = 1'b0;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND: begin
                        regs_d[rd_idx] = alu_res;
                        gt_d           = (rd_val > rs_val);
                        pc_d           = pc_inc;
                        i_req_d        = 1'b1;
                    end
                    OP_LDH: begin
                        regs_d[dir_idx][7:4] = imm;
                        pc_d                 = pc_inc;
                        i_req_d              = 1'b1;
                    end
                    OP_LDL: begin
                        regs_d[dir_idx][3:0] = imm;
                        pc_d                 = pc_inc;
                        i_req_d              = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        d_req_d   = 1'b1;
                        d_we_d    = (op == OP_ST);
                        d_addr_d  = rs_val[DADDR_WIDTH-1:0];
                        d_wdata_d = rd_val;
                    end
                    default: begin
                        if (is_halt) begin
                            halted_d = 1'b1;
                        end else begin
                            if (gt_q) begin
                                pc_d = ir_q[4] ? (pc_q - imm_pc) : (pc_q + imm_pc);
                            end else begin
                                pc_d = pc_inc;
                            end
                            i_req_d = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (mem_done) begin
                    if (!d_we_q) begin
                        regs_d[rd_idx] = d_rdata;
                    end
                    pc_d    = pc_inc;
                    d_req_d = 1'b0;
                    i_req_d = 1'b1;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                i_req_d = 1'b0;
            end
        endcase
    end

    // Architectural state and registered outputs; reset drops any pending request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            for (int k = 0; k < 4; k++) begin
                regs_q[k] <= '0;
            end
            gt_q      <= 1'b0;
            ir_q      <= '0;
            i_req_q   <= 1'b0;
            d_req_q   <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            for (int k = 0; k < 4; k++) begin
                regs_q[k] <= regs_d[k];
            end
            gt_q      <= gt_d;
            ir_q      <= ir_d;
            i_req_q   <= i_req_d;
            d_req_q   <= d_req_d;
            d_we_q    <= d_we_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            halted_q  <= halted_d;
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: an 8-bit core with wait-state memory models and a scoreboard
// of expected fetches and data accesses (address, data, cycle), plus a 16-bit core
// running a short program whose stores are compared against expected values.
module tb_mc_cpu_core;

    typedef struct {
        logic [7:0] addr;
        int         cyc;
    } fetch_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } data_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_ready;
    logic [7:0]  i_data;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [7:0]  d_wdata;
    logic        d_ready;
    logic [7:0]  d_rdata;
    logic        halted;

    logic        rst16;
    logic        i_req16;
    logic [7:0]  i_addr16;
    logic [7:0]  i_data16;
    logic        d_req16;
    logic        d_we16;
    logic [7:0]  d_addr16;
    logic [15:0] d_wdata16;
    logic        halted16;

    logic [7:0]  imem [256];
    logic [7:0]  imem16 [256];

    fetch_t      expFetch [$];
    data_t       expData [$];
    logic [15:0] expStore16 [$];

    int          checks;
    int          failures;
    int          cyc;
    int          stallPc;
    int          stallCycles;
    int          dataWait;
    int          iCount;
    int          dCount;
    logic [7:0]  iAddrFirst;
    logic        dWeFirst;
    logic [7:0]  dAddrFirst;
    logic [7:0]  dWdataFirst;
    fetch_t      fetchEntry;
    data_t       dataEntry;
    logic [15:0] store16Entry;

    mc_cpu_core dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .halted  (halted)
    );

    mc_cpu_core #(
        .DATA_WIDTH  (16),
        .PC_WIDTH    (8),
        .DADDR_WIDTH (8)
    ) dut16 (
        .clk     (clk),
        .rst     (rst16),
        .i_req   (i_req16),
        .i_addr  (i_addr16),
        .i_ready (i_req16),
        .i_data  (i_data16),
        .d_req   (d_req16),
        .d_we    (d_we16),
        .d_addr  (d_addr16),
        .d_wdata (d_wdata16),
        .d_ready (d_req16),
        .d_rdata (16'h0000),
        .halted  (halted16)
    );

    assign i_data   = imem[i_addr];
    assign i_data16 = imem16[i_addr16];
    assign d_rdata  = 8'h3C;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release, used to time-stamp every accepted request.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Memory models for the 8-bit core plus the scoreboard pop on every accepted request.
    always @(negedge clk) begin
        if (rst) begin
            iCount  = 0;
            dCount  = 0;
            i_ready = 1'b0;
            d_ready = 1'b0;
        end else begin
            if (i_req) begin
                if (iCount == 0) iAddrFirst = i_addr;
                iCount++;
                i_ready = (iCount > ((32'(i_addr) == stallPc) ? stallCycles : 0));
                if (i_ready) begin
                    checkOutput("fetch_expected", 32'(expFetch.size() != 0), 1);
                    if (expFetch.size() != 0) begin
                        fetchEntry = expFetch.pop_front();
                        checkOutput("fetch_addr", 32'(i_addr), 32'(fetchEntry.addr));
                        checkOutput("fetch_cycle", cyc, fetchEntry.cyc);
                    end
                    checkOutput("fetch_addr_stable", 32'(i_addr), 32'(iAddrFirst));
                    checkOutput("one_outstanding", 32'(d_req), 0);
                end
            end else begin
                iCount  = 0;
                i_ready = 1'b0;
            end
            if (d_req) begin
                if (dCount == 0) begin
                    dWeFirst    = d_we;
                    dAddrFirst  = d_addr;
                    dWdataFirst = d_wdata;
                end
                dCount++;
                d_ready = (dCount > dataWait);
                if (d_ready) begin
                    checkOutput("data_expected", 32'(expData.size() != 0), 1);
                    if (expData.size() != 0) begin
                        dataEntry = expData.pop_front();
                        checkOutput("data_we", 32'(d_we), 32'(dataEntry.we));
                        checkOutput("data_addr", 32'(d_addr), 32'(dataEntry.addr));
                        if (dataEntry.we) checkOutput("data_wdata", 32'(d_wdata), 32'(dataEntry.wdata));
                        checkOutput("data_cycle", cyc, dataEntry.cyc);
                    end
                    checkOutput("data_stable", {15'd0, d_we, d_addr, d_wdata}, {15'd0, dWeFirst, dAddrFirst, dWdataFirst});
                end
            end else begin
                dCount  = 0;
                d_ready = 1'b0;
            end
        end
    end

    // Store monitor for the 16-bit core (zero-wait memories, one MEM cycle per store).
    always @(negedge clk) begin
        if (!rst16 && d_req16 && d_we16) begin
            checkOutput("store16_expected", 32'(expStore16.size() != 0), 1);
            if (expStore16.size() != 0) begin
                store16Entry = expStore16.pop_front();
                checkOutput("store16_wdata", 32'(d_wdata16), 32'(store16Entry));
                checkOutput("store16_addr", 32'(d_addr16), 0);
            end
        end
    end

    task automatic expectFetch(input logic [7:0] addr, input int c);
        fetch_t e;
        e.addr = addr;
        e.cyc  = c;
        expFetch.push_back(e);
    endtask

    task automatic expectData(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input int c);
        data_t e;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.cyc   = c;
        expData.push_back(e);
    endtask

    // Hold reset, fill instruction memory with HALT and clear the scoreboard and wait settings.
    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 256; k++) imem[k] = 8'hE0;
        expFetch.delete();
        expData.delete();
        stallPc     = -1;
        stallCycles = 0;
        dataWait    = 0;
    endtask

    // Release reset, run to HALT within a budget, then confirm the core stays quiet.
    task automatic applyStimulus(input int budget);
        int n;
        int noisy;
        @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt_reached", 32'(halted), 1);
        checkOutput("fetch_drained", expFetch.size(), 0);
        checkOutput("data_drained", expData.size(), 0);
        noisy = 0;
        repeat (20) begin
            @(negedge clk);
            if (i_req || d_req || !halted) noisy++;
        end
        checkOutput("halt_quiet", noisy, 0);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst16    = 1'b1;
        for (int k = 0; k < 256; k++) imem16[k] = 8'hE0;

        // Reset state of all outputs.
        applyReset();
        checkOutput("reset_outputs", {8'd0, i_req, d_req, d_we, halted, i_addr, d_addr, d_wdata},
                    32'd0);

        // LDL r0,5 ; LDH r0,A ; ST r0,[r2] ; HALT, zero-wait.
        applyReset();
        imem[0] = 8'hC5; imem[1] = 8'h6A; imem[2] = 8'hA4; imem[3] = 8'hE0;
        expectFetch(0, 1); expectFetch(1, 3); expectFetch(2, 5);
        expectData(1'b1, 8'h00, 8'hA5, 7);
        expectFetch(3, 8);
        applyStimulus(100);

        // Same program with three stall cycles on the fetch at PC 1.
        applyReset();
        imem[0] = 8'hC5; imem[1] = 8'h6A; imem[2] = 8'hA4; imem[3] = 8'hE0;
        stallPc = 1; stallCycles = 3;
        expectFetch(0, 1); expectFetch(1, 6); expectFetch(2, 8);
        expectData(1'b1, 8'h00, 8'hA5, 10);
        expectFetch(3, 11);
        applyStimulus(100);

        // LDL r1,7 ; ST r1,[r2] ; LD r3,[r2] ; ST r3,[r2] ; HALT with two data wait states.
        applyReset();
        imem[0] = 8'hD7; imem[1] = 8'hAC; imem[2] = 8'h9C; imem[3] = 8'hBC; imem[4] = 8'hE0;
        dataWait = 2;
        expectFetch(0, 1); expectFetch(1, 3);
        expectData(1'b1, 8'h00, 8'h07, 7);
        expectFetch(2, 8);
        expectData(1'b0, 8'h00, 8'h00, 12);
        expectFetch(3, 13);
        expectData(1'b1, 8'h00, 8'h3C, 17);
        expectFetch(4, 18);
        applyStimulus(100);

        // r0=3, r1=1, SUB sets GT; BGT back by 5 from PC 3 wraps to 254.
        applyReset();
        imem[0] = 8'hC3; imem[1] = 8'hD1; imem[2] = 8'h22; imem[3] = 8'hF5; imem[254] = 8'hE0;
        expectFetch(0, 1); expectFetch(1, 3); expectFetch(2, 5); expectFetch(3, 7);
        expectFetch(254, 9);
        applyStimulus(100);

        // r0=1, r1=3, SUB clears GT and leaves 0xFE; BGT falls through to the store.
        applyReset();
        imem[0] = 8'hC1; imem[1] = 8'hD3; imem[2] = 8'h22; imem[3] = 8'hF5; imem[4] = 8'hA4;
        imem[5] = 8'hE0;
        expectFetch(0, 1); expectFetch(1, 3); expectFetch(2, 5); expectFetch(3, 7);
        expectFetch(4, 9);
        expectData(1'b1, 8'h00, 8'hFE, 11);
        expectFetch(5, 12);
        applyStimulus(100);

        // Reset asserted while a store waits in MEM, then a clean restart from PC 0.
        applyReset();
        imem[0] = 8'hA4; imem[1] = 8'hE0;
        dataWait = 50;
        expectFetch(0, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (cyc < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("mem_req_active", 32'(d_req), 1);
        rst = 1'b1;
        #1;
        checkOutput("reset_drops_req", {30'd0, d_req, i_req}, 32'd0);
        repeat (2) @(negedge clk);
        expFetch.delete();
        expData.delete();
        dataWait = 0;
        expectFetch(0, 1);
        expectData(1'b1, 8'h00, 8'h00, 3);
        expectFetch(1, 4);
        applyStimulus(100);

        // 16-bit core: wrap to 0xFFFF, ADD back to zero with GT set, LDH touches bits 7:4 only.
        imem16[0]  = 8'hD1;  // LDL r1,1
        imem16[1]  = 8'h22;  // SUB r0,r1 -> FFFF, GT=0
        imem16[2]  = 8'hA4;  // ST r0
        imem16[3]  = 8'h02;  // ADD r0,r1 -> 0000, GT=1
        imem16[4]  = 8'hA4;  // ST r0
        imem16[5]  = 8'hE2;  // BGT +2 -> PC 7
        imem16[6]  = 8'hE0;  // HALT if the branch is not taken
        imem16[7]  = 8'h7A;  // LDH r1,A -> 00A1
        imem16[8]  = 8'h22;  // SUB r0,r1 -> FF5F
        imem16[9]  = 8'h63;  // LDH r0,3 -> FF3F
        imem16[10] = 8'hA4;  // ST r0
        imem16[11] = 8'hE0;  // HALT
        expStore16.push_back(16'hFFFF);
        expStore16.push_back(16'h0000);
        expStore16.push_back(16'hFF3F);
        @(negedge clk);
        #1 rst16 = 1'b0;
        n = 0;
        while (!halted16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("halt16_reached", 32'(halted16), 1);
        checkOutput("store16_drained", expStore16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
